// File: rtl/jesd_rx_link_ctrl.sv
// JESD204B receive link controller: LMFC alignment to SYSREF, SYNC~ handshake
// through CGS and ILAS, per-lane error monitoring with automatic resync.
module jesd_rx_lane #(
    parameter int CGS_COUNT  = 4,
    parameter int ERR_THRESH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_cgs,
    input  logic i_ilas,
    input  logic i_data,
    input  logic i_lmfc,
    input  logic i_comma,
    input  logic i_ila,
    input  logic i_err,
    output logic o_cgs_ok,
    output logic o_ila_seen,
    output logic o_err_hit
);
    localparam int CW = $clog2(CGS_COUNT + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    logic [CW-1:0] r_cgs_cnt;
    logic [EW-1:0] r_err_cnt;
    logic [EW-1:0] w_err_nxt;
    logic          r_ila_seen;

    // An error in the LMFC pulse cycle starts the new multiframe's count at 1
    always_comb begin
        w_err_nxt = r_err_cnt;
        if (i_lmfc)
            w_err_nxt = EW'(i_err);
        else if (i_err && r_err_cnt != EW'(ERR_THRESH))
            w_err_nxt = r_err_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cgs_cnt  <= '0;
            r_err_cnt  <= '0;
            r_ila_seen <= 1'b0;
        end else begin
            if (i_clr)
                r_cgs_cnt <= '0;
            else if (i_cgs) begin
                if (i_comma && !i_err) begin
                    if (r_cgs_cnt != CW'(CGS_COUNT))
                        r_cgs_cnt <= r_cgs_cnt + 1'b1;
                end else
                    r_cgs_cnt <= '0;
            end
            r_ila_seen <= i_ilas & (r_ila_seen | i_ila);
            r_err_cnt  <= i_data ? w_err_nxt : '0;
        end
    end

    assign o_cgs_ok   = (r_cgs_cnt == CW'(CGS_COUNT));
    assign o_ila_seen = r_ila_seen;
    assign o_err_hit  = i_data & (w_err_nxt == EW'(ERR_THRESH));
endmodule

module jesd_rx_link_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int LMFC_PERIOD = 8,
    parameter int CGS_COUNT   = 4,
    parameter int ILAS_MF     = 4,
    parameter int ERR_THRESH  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic                           sysref_i,
    input  logic [NUM_LANES-1:0]           comma_det_i,
    input  logic [NUM_LANES-1:0]           ila_start_i,
    input  logic [NUM_LANES-1:0]           lane_err_i,
    output logic                           sync_n_o,
    output logic                           lmfc_o,
    output logic [$clog2(LMFC_PERIOD)-1:0] lmfc_cnt_o,
    output logic [NUM_LANES-1:0]           lane_cgs_ok_o,
    output logic                           link_up_o,
    output logic [2:0]                     state_o,
    output logic [7:0]                     resync_cnt_o
);
    localparam int LW = $clog2(LMFC_PERIOD);
    localparam int IW = $clog2(ILAS_MF + 1);
    localparam logic [LW-1:0] LMFC_LAST = LW'(LMFC_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WAIT_SYSREF = 3'd1, S_CGS = 3'd2,
        S_ILAS = 3'd3, S_DATA = 3'd4, S_RESYNC = 3'd5
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_sysref_q, r_sysref_seen, r_lmfc;
    logic [LW-1:0]  r_lmfc_cnt;
    logic [IW-1:0]  r_ilas_cnt;
    logic [7:0]     r_resync_cnt;
    logic           w_edge, w_seen_nxt;
    logic [LW-1:0]  w_lmfc_nxt;
    logic [NUM_LANES-1:0] w_cgs_ok, w_ila_seen, w_err_hit;

    assign w_edge     = sysref_i & ~r_sysref_q;
    assign w_lmfc_nxt = (w_edge || r_lmfc_cnt == LMFC_LAST) ? '0 : r_lmfc_cnt + 1'b1;
    assign w_seen_nxt = (r_state == S_IDLE) ? 1'b0 : (r_sysref_seen | w_edge);

    // Pulse is registered alongside the count, so a realign on a wrap is one pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sysref_q    <= 1'b0;
            r_sysref_seen <= 1'b0;
            r_lmfc_cnt    <= '0;
            r_lmfc        <= 1'b0;
            r_ilas_cnt    <= '0;
            r_resync_cnt  <= '0;
            r_state       <= S_IDLE;
        end else begin
            r_sysref_q    <= sysref_i;
            r_sysref_seen <= w_seen_nxt;
            r_lmfc_cnt    <= w_lmfc_nxt;
            r_lmfc        <= (w_lmfc_nxt == '0) & w_seen_nxt;
            if (r_state != S_ILAS)
                r_ilas_cnt <= '0;
            else if (r_lmfc)
                r_ilas_cnt <= r_ilas_cnt + 1'b1;
            if (r_state == S_RESYNC && r_resync_cnt != 8'hFF)
                r_resync_cnt <= r_resync_cnt + 1'b1;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (enable_i) w_state_nxt = S_WAIT_SYSREF;
            S_WAIT_SYSREF: if (w_edge) w_state_nxt = S_CGS;
            S_CGS:         if (&w_cgs_ok && r_lmfc) w_state_nxt = S_ILAS;
            S_ILAS: begin
                if (|lane_err_i)
                    w_state_nxt = S_RESYNC;
                else if (r_lmfc && r_ilas_cnt == IW'(ILAS_MF - 1))
                    w_state_nxt = (&(w_ila_seen | ila_start_i)) ? S_DATA : S_RESYNC;
            end
            S_DATA:        if (|w_err_hit) w_state_nxt = S_RESYNC;
            S_RESYNC:      w_state_nxt = S_CGS;
            default:       w_state_nxt = S_IDLE;
        endcase
        if (!enable_i)
            w_state_nxt = S_IDLE;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        jesd_rx_lane #(.CGS_COUNT(CGS_COUNT), .ERR_THRESH(ERR_THRESH)) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .i_clr      (r_state == S_IDLE || r_state == S_RESYNC),
            .i_cgs      (r_state == S_CGS),
            .i_ilas     (r_state == S_ILAS),
            .i_data     (r_state == S_DATA),
            .i_lmfc     (r_lmfc),
            .i_comma    (comma_det_i[g]),
            .i_ila      (ila_start_i[g]),
            .i_err      (lane_err_i[g]),
            .o_cgs_ok   (w_cgs_ok[g]),
            .o_ila_seen (w_ila_seen[g]),
            .o_err_hit  (w_err_hit[g])
        );
    end

    assign sync_n_o      = (r_state == S_ILAS) || (r_state == S_DATA);
    assign link_up_o     = (r_state == S_DATA);
    assign lmfc_o        = r_lmfc;
    assign lmfc_cnt_o    = r_lmfc_cnt;
    assign lane_cgs_ok_o = w_cgs_ok;
    assign state_o       = r_state;
    assign resync_cnt_o  = r_resync_cnt;
endmodule

// File: doc/jesd_rx_link_ctrl.md
Name: jesd_rx_link_ctrl

Overview:
Receive-side JESD204B link controller for the ZC706 four-lane ADC interface (lanes A–D).
- Aligns a local LMFC counter to SYSREF.
- Drives SYNC~ through code-group synchronisation (CGS) and the initial lane alignment sequence (ILAS), then reports link-up.
- Monitors per-lane errors and forces a resync when an error threshold is reached.
- Sits between the lane decoders (comma, /R/ and error flags) and the SYNC~ output buffer of the ADC PHY.

Parameters:
NUM_LANES, 4, number of lanes (A..D).
LMFC_PERIOD, 8, clk_i cycles per multiframe (≥2).
CGS_COUNT, 4, consecutive K28.5 cycles required per lane.
ILAS_MF, 4, multiframes allowed for ILAS.
ERR_THRESH, 4, per-lane errors within one multiframe that trigger a resync (≤LMFC_PERIOD).

Ports:
clk_i  in  1  link clock.
rst_i  in  1  asynchronous, active-high reset.
enable_i  in  1  link enable; low forces IDLE.
sysref_i  in  1  SYSREF, already synchronised to clk_i.
comma_det_i  in  NUM_LANES  lane character is K28.5 this cycle.
ila_start_i  in  NUM_LANES  lane character is /R/ (K28.0) this cycle.
lane_err_i  in  NUM_LANES  disparity / not-in-table strobe.
sync_n_o  out  1  SYNC~, active low.
lmfc_o  out  1  LMFC boundary pulse.
lmfc_cnt_o  out  clog2(LMFC_PERIOD)  LMFC phase.
lane_cgs_ok_o  out  NUM_LANES  lane has achieved CGS.
link_up_o  out  1  link in DATA state.
state_o  out  3  FSM state.
resync_cnt_o  out  8  resync counter, saturating.

Behaviour:
Reset: all outputs are 0, so sync_n_o=0 (SYNC requested), and state=IDLE.

LMFC counter:
- sysref_q is registered; a SYSREF edge is defined as sysref_i & ~sysref_q.
- lmfc_cnt increments mod LMFC_PERIOD each cycle.
- On an edge, lmfc_cnt loads 0 on the next clock and the sticky flag sysref_seen is set.
- lmfc_o=1 for exactly the cycles where lmfc_cnt_o has just become 0, by wrap or by realign, and only once sysref_seen=1. An edge that coincides with a natural wrap gives one pulse, not two.
- sysref_seen clears only on reset or in IDLE.

State encoding: IDLE=0, WAIT_SYSREF=1, CGS=2, ILAS=3, DATA=4, RESYNC=5.

IDLE:
- sync_n_o=0; lane counters and sticky flags are cleared.
- Goes to WAIT_SYSREF when enable_i=1.

WAIT_SYSREF:
- sync_n_o=0.
- On a SYSREF edge, goes to CGS.

CGS:
- sync_n_o=0.
- Per lane, a counter increments (saturating at CGS_COUNT) when comma_det_i=1 and lane_err_i=0; otherwise it resets to 0.
- lane_cgs_ok_o[i] = (counter==CGS_COUNT).
- When all lanes are ok and lmfc_o=1 in the same cycle, goes to ILAS. sync_n_o=1 from the next cycle onward.

ILAS:
- sync_n_o=1.
- Per-lane sticky ila_seen is set by ila_start_i.
- The controller counts lmfc_o pulses. When ILAS_MF pulses have been counted:
  - all ila_seen set → DATA;
  - otherwise → RESYNC.
- A lane_err_i on any lane during ILAS → RESYNC.

DATA:
- link_up_o=1, sync_n_o=1.
- A per-lane error counter increments (saturating) on lane_err_i and clears on each lmfc_o pulse.
- An error in the same cycle as lmfc_o loads 1.
- Any lane counter reaching ERR_THRESH → RESYNC.

RESYNC (one cycle):
- sync_n_o=0, link_up_o=0.
- Clears lane, error, sticky and ILAS counters.
- resync_cnt increments (saturating at 255).
- Goes to CGS next cycle. LMFC alignment is kept and WAIT_SYSREF is not re-entered.

Global rules:
- enable_i=0 in any state → IDLE next cycle. This overrides all other transitions; resync_cnt is kept.
- A SYSREF edge outside WAIT_SYSREF only realigns the LMFC counter. The ILAS pulse count continues across the realign.
- Reset asserted mid-operation immediately forces the reset values, independent of the clock.

Test Plan:
- Bring-up, LMFC_PERIOD=8, CGS_COUNT=4, ILAS_MF=4:
  - Stimulus: enable, SYSREF edge at cycle 10, all commas from cycle 12.
  - Response: lmfc_cnt_o=0 at cycle 11; CGS ok at cycle 16; sync_n_o rises the cycle after the first lmfc_o at or after cycle 16; /R/ on all lanes in ILAS → link_up_o=1 after 4 pulses.
- Comma break in CGS:
  - Stimulus: lane 2 drops comma_det_i for 1 cycle after 3 good cycles.
  - Response: lane_cgs_ok_o[2] stays 0 until 4 further consecutive commas; sync_n_o stays 0.
- ILAS timeout:
  - Stimulus: lane 3 never asserts ila_start_i.
  - Response: RESYNC after the 4th lmfc_o pulse; resync_cnt_o=1; sync_n_o=0; back in CGS.
- DATA error threshold:
  - Stimulus: 4 lane_err_i on lane 0 within one multiframe → RESYNC.
  - Stimulus: 3 errors, an lmfc_o pulse, then 3 more errors.
  - Response: in the second case the link stays up.
- SYSREF realign in DATA:
  - Stimulus: SYSREF edge while lmfc_cnt_o=5.
  - Response: next cycle cnt=0 with lmfc_o=1, link_up_o stays 1. An edge at cnt=7 gives a single pulse.
- Mid-operation control:
  - Stimulus: deassert enable_i in DATA.
  - Response: IDLE next cycle, sync_n_o=0, resync_cnt_o unchanged.
  - Stimulus: assert rst_i asynchronously.
  - Response: all outputs 0 before the next clock edge.
